dr_alm_rr_scheduler: RTL and testbench
======================================

// Module: dr_alm_rr_scheduler
// PURPOSE
//  Shares one combinational dr_alm_core approximate log multiplier between NUM_REQ requesters.
//  Each requester has a valid/ready operand port. Arbitration is round-robin.
//  Operands are registered into the core; its product is registered, tagged with the
//  requester ID and returned on a single valid/ready result port.
//  Sits between the MAC/accelerator front-ends and the shared multiplier datapath.
// PARAMETERS
//  WIDTH       16  operand width (8 or 16), passed to dr_alm_core
//  KEEP_WIDTH  5   truncation width t, passed to dr_alm_core
//  NUM_REQ     4   number of requesters (2..8)
//  CNT_W       32  width of completed-operation counter
// PORTS
//  i_clk        in   1                 clock, all state on rising edge
//  i_rst        in   1                 synchronous reset, active-high
//  i_req_valid  in   NUM_REQ           per-requester operand valid
//  o_req_ready  out  NUM_REQ           per-requester accept (one-hot or zero)
//  i_req_a      in   NUM_REQ*WIDTH     signed operand A, requester r at [r*WIDTH +: WIDTH]
//  i_req_b      in   NUM_REQ*WIDTH     signed operand B, same packing
//  o_res_valid  out  1                 result valid
//  i_res_ready  in   1                 downstream accepts result
//  o_res_z      out  2*WIDTH           signed approximate product
//  o_res_id     out  $clog2(NUM_REQ)   requester ID of o_res_z
//  o_busy       out  1                 any pipeline stage occupied
//  o_op_count   out  CNT_W             results delivered (res_valid & res_ready)
// BEHAVIOUR
//  - Single clock; i_rst is synchronous and active-high.
//  - Reset: s1_valid=0, s2_valid=0, rr_ptr=0, o_op_count=0.
//    Outputs during and after reset: o_res_valid=0, o_req_ready=0, o_busy=0; o_res_z/o_res_id=0.
//  - Reset mid-operation flushes both stages; in-flight ops are dropped, not delivered.
//  - Pipeline: S1 holds {a,b,id}. S2 holds {z,id}, with z = dr_alm_core(S1.a, S1.b).
//  - Latency: accept at cycle N -> o_res_valid at N+2 if unstalled. Throughput 1 op/cycle.
//  - Stall rules:
//    - stall2 = s2_valid & ~i_res_ready.
//    - adv1 = s1_valid & ~stall2 (S1 moves into S2).
//    - s1_free = ~s1_valid | adv1.
//  - Grant: when s1_free, the round-robin arbiter picks the first valid requester at or after
//    rr_ptr, modulo NUM_REQ.
//    - o_req_ready is one-hot on the winner only; all zero when ~s1_free.
//    - o_req_ready depends combinationally on i_req_valid and i_res_ready. No combinational
//      path from i_req_a/i_req_b to any output.
//  - On handshake (valid & ready) for requester g: S1 <= {a_g, b_g, g}; rr_ptr <= (g+1) mod NUM_REQ.
//  - With no grant, rr_ptr holds.
//  - Simultaneous requests: the lowest index at/after rr_ptr wins. Others keep valid asserted and
//    must hold operands stable (AXI-style, no retraction).
//  - Wrap: requester NUM_REQ-1 granted -> rr_ptr=0.
//  - Output: o_res_valid = s2_valid; o_res_z and o_res_id are driven from S2 registers and held
//    stable while stalled.
//  - Simultaneous S2 drain + S1 advance + new grant in one cycle is legal. This is full throughput.
//  - Zero operands: the core returns 0 and the result is still delivered normally with its ID.
//  - Most-negative operand (e.g. -32768 at WIDTH=16): result is whatever the core produces.
//    No special case in the scheduler.
//  - o_op_count increments on o_res_valid & i_res_ready and wraps modulo 2^CNT_W.
//  - o_busy = s1_valid | s2_valid.
// STRUCTURE
//  - Package dr_alm_pkg:
//    - typedef req_id_t (logic [$clog2(NUM_REQ)-1:0] for the default build)
//    - localparam MAX_REQ = 8
//    - typedef struct s1_t {a, b, id} and typedef struct s2_t {z, id}
//  - Sub-module rr_arbiter #(N):
//    - ports i_clk, i_rst, i_req[N], i_en, o_gnt[N] (one-hot), o_gnt_id
//    - owns rr_ptr; pointer updates only when i_en and a grant occur
//  - Top: the two pipeline registers, the stall logic, one dr_alm_core instance, the counter.
// TESTING (WIDTH=16, KEEP_WIDTH=5, NUM_REQ=4; expected z always from a standalone dr_alm_core model)
//  1. Reset: assert i_rst 2 cycles with all i_req_valid=1 -> o_req_ready=0, o_res_valid=0,
//     o_op_count=0. Release -> requester 0 granted first.
//  2. Single op: req1 a=3, b=5, i_res_ready=1 -> granted cycle N; cycle N+2 o_res_valid=1,
//     o_res_id=1, o_res_z=core(3,5).
//  3. Fairness: all 4 valid continuously, i_res_ready=1 -> grant order 0,1,2,3,0,...
//     One result per cycle; o_op_count=8 after 8 deliveries.
//  4. Backpressure: i_res_ready=0 for 5 cycles with 3 requesters valid
//     -> after 2 accepts, o_req_ready stays 0 and o_res_z/o_res_id hold stable.
//     Release -> results drain in order, none lost or duplicated.
//  5. Zero/sign: req2 a=0, b=-7 -> z=0, id=2. Req3 a=-4, b=6 -> z=core(-4,6), which is negative.
//  6. Mid-op reset: accept 2 ops, assert i_rst while S2 valid -> next cycle o_res_valid=0,
//     o_busy=0, o_op_count=0. No stale result appears after release.

Source files
------------

// File: rtl/dr_alm_pkg.sv
// Shared types and helpers for the dr_alm round-robin multiplier scheduler.
package dr_alm_pkg;

   localparam int MAX_REQ     = 8;
   localparam int DEF_WIDTH   = 16;
   localparam int DEF_NUM_REQ = 4;

   typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_id_t;

   // Stage payloads for the default build
   typedef struct packed {
      logic [DEF_WIDTH-1:0] a;
      logic [DEF_WIDTH-1:0] b;
      req_id_t              id;
   } s1_t;

   typedef struct packed {
      logic [2*DEF_WIDTH-1:0] z;
      req_id_t                id;
   } s2_t;

   // Round-robin successor of index g among n requesters
   function automatic int rr_next(input int g, input int n);
      return (g + 1 >= n) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/dr_alm_core.sv
// Combinational dynamic-range approximate log multiplier (signed, sign-magnitude).
// Each operand's fraction below its leading one is cut to KEEP_WIDTH-1 bits and
// a forced trailing 1 is appended to centre the truncation error.
module dr_alm_core #(
   parameter int WIDTH      = 16,
   parameter int KEEP_WIDTH = 5
) (
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic [2*WIDTH-1:0] o_z
);

   localparam int PW = 2 * WIDTH + KEEP_WIDTH;

   logic [WIDTH-1:0]      w_mag_a;
   logic [WIDTH-1:0]      w_mag_b;
   int                    w_ka;
   int                    w_kb;
   int                    w_k;
   logic [KEEP_WIDTH-1:0] w_ma;
   logic [KEEP_WIDTH-1:0] w_mb;
   logic [KEEP_WIDTH:0]   w_sum;
   logic [2*WIDTH-1:0]    w_pmag;
   logic                  w_zero;
   logic                  w_neg;

   // Log-domain add of both operands, then antilog and restore the sign
   always_comb begin
      w_mag_a = i_a[WIDTH-1] ? (~i_a + 1'b1) : i_a;
      w_mag_b = i_b[WIDTH-1] ? (~i_b + 1'b1) : i_b;
      w_ka = 0;
      w_kb = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (w_mag_a[i]) w_ka = i;
         if (w_mag_b[i]) w_kb = i;
      end
      // Shifting right by k leaves the leading one above the kept fraction bits
      w_ma = {(KEEP_WIDTH-1)'({w_mag_a, {(KEEP_WIDTH-1){1'b0}}} >> w_ka), 1'b1};
      w_mb = {(KEEP_WIDTH-1)'({w_mag_b, {(KEEP_WIDTH-1){1'b0}}} >> w_kb), 1'b1};
      w_sum = {1'b0, w_ma} + {1'b0, w_mb};
      w_k = w_ka + w_kb + int'(w_sum[KEEP_WIDTH]);
      w_pmag = (2*WIDTH)'(({{(PW-KEEP_WIDTH-1){1'b0}}, 1'b1, w_sum[KEEP_WIDTH-1:0]} << w_k)
                          >> KEEP_WIDTH);
      w_zero = (w_mag_a == '0) || (w_mag_b == '0);
      w_neg  = i_a[WIDTH-1] ^ i_b[WIDTH-1];
      o_z = w_zero ? '0 : (w_neg ? (~w_pmag + 1'b1) : w_pmag);
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the pointer
// moves past the winner only when a grant is actually issued.
module rr_arbiter
   import dr_alm_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [N-1:0]         i_req,
   input  logic                 i_en,
   output logic [N-1:0]         o_gnt,
   output logic [$clog2(N)-1:0] o_gnt_id
);

   localparam int ID_W = $clog2(N);

   logic [ID_W-1:0] r_ptr;
   logic [ID_W-1:0] w_idx;
   logic [ID_W-1:0] w_win;
   logic            w_found;

   // Rotating priority search starting at the pointer
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int i = 0; i < N; i++) begin
         w_idx = ID_W'((int'(r_ptr) + i) % N);
         if (!w_found && i_req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
      o_gnt = '0;
      if (i_en && w_found) o_gnt[w_win] = 1'b1;
      o_gnt_id = w_win;
   end

   // Pointer advances past the winner on a grant, holds otherwise
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= '0;
      end else if (i_en && w_found) begin
         r_ptr <= ID_W'(rr_next(int'(w_win), N));
      end
   end

endmodule

// File: rtl/dr_alm_rr_scheduler.sv
// Shares one dr_alm_core between NUM_REQ requesters: round-robin grant into an
// operand stage (S1), registered product stage (S2) tagged with requester ID.
module dr_alm_rr_scheduler
   import dr_alm_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int KEEP_WIDTH = 5,
   parameter int NUM_REQ    = 4,
   parameter int CNT_W      = 32
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [NUM_REQ-1:0]         i_req_valid,
   output logic [NUM_REQ-1:0]         o_req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   i_req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   i_req_b,
   output logic                       o_res_valid,
   input  logic                       i_res_ready,
   output logic [2*WIDTH-1:0]         o_res_z,
   output logic [$clog2(NUM_REQ)-1:0] o_res_id,
   output logic                       o_busy,
   output logic [CNT_W-1:0]           o_op_count
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic               r_s1_valid;
   logic [WIDTH-1:0]   r_s1_a;
   logic [WIDTH-1:0]   r_s1_b;
   logic [ID_W-1:0]    r_s1_id;
   logic               r_s2_valid;
   logic [2*WIDTH-1:0] r_s2_z;
   logic [ID_W-1:0]    r_s2_id;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_stall2;
   logic               w_adv1;
   logic               w_s1_free;
   logic               w_arb_en;
   logic               w_hs;
   logic               w_deliver;
   logic [NUM_REQ-1:0] w_gnt;
   logic [ID_W-1:0]    w_gnt_id;
   logic [WIDTH-1:0]   w_a;
   logic [WIDTH-1:0]   w_b;
   logic [2*WIDTH-1:0] w_core_z;

   // Stall/advance decisions; grants are suppressed while reset is held
   always_comb begin
      w_deliver = r_s2_valid & i_res_ready;
      w_stall2  = r_s2_valid & ~i_res_ready;
      w_adv1    = r_s1_valid & ~w_stall2;
      w_s1_free = ~r_s1_valid | w_adv1;
      w_arb_en  = w_s1_free & ~i_rst;
      w_hs      = |w_gnt;
   end

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_req    (i_req_valid),
      .i_en     (w_arb_en),
      .o_gnt    (w_gnt),
      .o_gnt_id (w_gnt_id)
   );

   // One-hot operand select of the granted requester
   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (w_gnt[r]) begin
            w_a = i_req_a[r*WIDTH +: WIDTH];
            w_b = i_req_b[r*WIDTH +: WIDTH];
         end
      end
   end

   dr_alm_core #(
      .WIDTH      (WIDTH),
      .KEEP_WIDTH (KEEP_WIDTH)
   ) u_core (
      .i_a (r_s1_a),
      .i_b (r_s1_b),
      .o_z (w_core_z)
   );

   // Two-stage pipeline and delivered-result counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_id    <= '0;
         r_s2_valid <= 1'b0;
         r_s2_z     <= '0;
         r_s2_id    <= '0;
         r_cnt      <= '0;
      end else begin
         if (w_hs) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= w_a;
            r_s1_b     <= w_b;
            r_s1_id    <= w_gnt_id;
         end else if (w_adv1) begin
            r_s1_valid <= 1'b0;
         end
         if (w_adv1) begin
            r_s2_valid <= 1'b1;
            r_s2_z     <= w_core_z;
            r_s2_id    <= r_s1_id;
         end else if (w_deliver) begin
            r_s2_valid <= 1'b0;
         end
         if (w_deliver) r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_req_ready = w_gnt;
   assign o_res_valid = r_s2_valid;
   assign o_res_z     = r_s2_z;
   assign o_res_id    = r_s2_id;
   assign o_busy      = r_s1_valid | r_s2_valid;
   assign o_op_count  = r_cnt;

endmodule

// File: tb/tb_dr_alm_rr_scheduler.sv
// Directed bench for dr_alm_rr_scheduler (WIDTH=16, KEEP_WIDTH=5, NUM_REQ=4).
module tb_dr_alm_rr_scheduler;

   localparam int WIDTH = 16;
   localparam int KW    = 5;
   localparam int NR    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NR-1:0] req_valid;
   logic [NR-1:0] req_ready;
   logic [63:0]   req_a;
   logic [63:0]   req_b;
   logic          res_valid;
   logic          res_ready;
   logic [31:0]   res_z;
   logic [1:0]    res_id;
   logic          busy;
   logic [31:0]   op_count;

   int n_checks = 0;
   int n_errors = 0;
   int exp_count = 0;

   always #5 clk = ~clk;

   dr_alm_rr_scheduler #(
      .WIDTH      (WIDTH),
      .KEEP_WIDTH (KW),
      .NUM_REQ    (NR),
      .CNT_W      (32)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_a     (req_a),
      .i_req_b     (req_b),
      .o_res_valid (res_valid),
      .i_res_ready (res_ready),
      .o_res_z     (res_z),
      .o_res_id    (res_id),
      .o_busy      (busy),
      .o_op_count  (op_count)
   );

   // Reference DR-ALM: integer log/antilog with KW-bit fractions, trailing 1 forced
   function automatic logic [31:0] alm_model(input int a, input int b);
      int     ma, mb, ka, kb, fa, fb, s, k;
      longint p;
      if (a == 0 || b == 0) return 32'd0;
      ma = (a < 0) ? -a : a;
      mb = (b < 0) ? -b : b;
      ka = 0;
      while ((1 << (ka + 1)) <= ma) ka++;
      kb = 0;
      while ((1 << (kb + 1)) <= mb) kb++;
      fa = (((ma - (1 << ka)) << (KW - 1)) >> ka) * 2 + 1;
      fb = (((mb - (1 << kb)) << (KW - 1)) >> kb) * 2 + 1;
      s = fa + fb;
      k = ka + kb;
      if (s >= (1 << KW)) begin
         k++;
         s -= (1 << KW);
      end
      p = (longint'((1 << KW) + s) << k) >> KW;
      if ((a < 0) != (b < 0)) p = -p;
      return p[31:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_op(input int id, input int a, input int b);
      req_a[id*WIDTH +: WIDTH] = 16'(a);
      req_b[id*WIDTH +: WIDTH] = 16'(b);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int          id;
      int          a;
      int          b;
      logic [31:0] exp_z;
   } vec_t;

   typedef struct {
      logic [3:0] valid;
      logic       rr;
      logic [3:0] exp_ready;
      logic       exp_rv;
      int         exp_id;
   } bp_t;

   vec_t vecs[6];
   bp_t  bps[9];
   int   fa[4];
   int   fb[4];

   // Single op on an idle pipe: grant, two-cycle latency, tagged result
   task automatic run_op(input int idx, input vec_t v);
      string tag;
      tag = $sformatf("vec%0d", idx);
      req_valid = '0;
      req_valid[v.id] = 1'b1;
      set_op(v.id, v.a, v.b);
      res_ready = 1'b1;
      @(negedge clk);
      check({tag, " ready"}, req_ready, 4'b1 << v.id);
      tick();
      req_valid = '0;
      @(negedge clk);
      check({tag, " valid N+1"}, res_valid, 1'b0);
      tick();
      @(negedge clk);
      check({tag, " valid N+2"}, res_valid, 1'b1);
      check({tag, " id"}, res_id, v.id);
      check({tag, " z"}, res_z, v.exp_z);
      tick();
      exp_count++;
   endtask

   initial begin
      vecs[0] = '{1, 3, 5, 32'd14};
      vecs[1] = '{2, 0, -7, 32'd0};
      vecs[2] = '{3, -4, 6, 32'hFFFF_FFE7};
      vecs[3] = '{0, -32768, -32768, 32'h4400_0000};
      vecs[4] = '{0, 32767, -1, alm_model(32767, -1)};
      vecs[5] = '{1, 100, 200, alm_model(100, 200)};

      bps[0] = '{4'b0111, 1'b0, 4'b0001, 1'b0, 0};
      bps[1] = '{4'b0110, 1'b0, 4'b0010, 1'b0, 0};
      bps[2] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 0};
      bps[3] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 0};
      bps[4] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 0};
      bps[5] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 0};
      bps[6] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1};
      bps[7] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2};
      bps[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0};

      // Reset held with every requester asking
      rst = 1'b1;
      req_valid = '1;
      req_a = '0;
      req_b = '0;
      res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst ready", req_ready, 4'b0000);
      check("rst res_valid", res_valid, 1'b0);
      check("rst op_count", op_count, 32'd0);
      check("rst busy", busy, 1'b0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("first grant", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      @(negedge clk);
      check("busy after grant", busy, 1'b1);
      tick();
      @(negedge clk);
      check("first res valid", res_valid, 1'b1);
      check("first res id", res_id, 0);
      check("first res z", res_z, 32'd0);
      tick();
      exp_count++;

      // Single ops, zero and sign cases
      for (int i = 0; i < 6; i++) run_op(i, vecs[i]);
      @(negedge clk);
      check("count after table", op_count, exp_count);
      tick();

      // Mid-operation reset: two ops stalled in the pipe are dropped
      res_ready = 1'b0;
      set_op(0, 10, 11);
      set_op(1, 12, 13);
      req_valid = 4'b0011;
      @(negedge clk);
      check("midrst grant0", req_ready, 4'b0001);
      tick();
      req_valid = 4'b0010;
      @(negedge clk);
      check("midrst grant1", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      @(negedge clk);
      check("midrst s2 valid", res_valid, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("midrst res_valid", res_valid, 1'b0);
      check("midrst busy", busy, 1'b0);
      check("midrst count", op_count, 32'd0);
      res_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         @(negedge clk);
         check($sformatf("midrst stale%0d", c), res_valid, 1'b0);
      end
      tick();

      // Fairness at full throughput, pointer starts at 0 after reset
      for (int r = 0; r < NR; r++) begin
         fa[r] = r * 7 - 9;
         fb[r] = 3 * r + 2;
         set_op(r, fa[r], fb[r]);
      end
      res_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         req_valid = (c < 8) ? 4'hF : 4'h0;
         @(negedge clk);
         if (c < 8) check($sformatf("fair grant%0d", c), req_ready, 4'b1 << (c % 4));
         else check($sformatf("fair idle%0d", c), req_ready, 4'b0000);
         if (c >= 2) begin
            check($sformatf("fair rv%0d", c), res_valid, 1'b1);
            check($sformatf("fair id%0d", c), res_id, (c - 2) % 4);
            check($sformatf("fair z%0d", c), res_z,
                  alm_model(fa[(c - 2) % 4], fb[(c - 2) % 4]));
         end else begin
            check($sformatf("fair rv%0d", c), res_valid, 1'b0);
         end
         tick();
      end
      @(negedge clk);
      check("fair count", op_count, 32'd8);
      tick();

      // Backpressure with three requesters, then drain in order
      rst = 1'b1;
      req_valid = '0;
      repeat (2) tick();
      rst = 1'b0;
      fa[0] = 21;    fb[0] = -3;
      fa[1] = -17;   fb[1] = -17;
      fa[2] = 1000;  fb[2] = 33;
      for (int r = 0; r < 3; r++) set_op(r, fa[r], fb[r]);
      for (int c = 0; c < 9; c++) begin
         req_valid = bps[c].valid;
         res_ready = bps[c].rr;
         @(negedge clk);
         check($sformatf("bp ready%0d", c), req_ready, bps[c].exp_ready);
         check($sformatf("bp rv%0d", c), res_valid, bps[c].exp_rv);
         if (bps[c].exp_rv) begin
            check($sformatf("bp id%0d", c), res_id, bps[c].exp_id);
            check($sformatf("bp z%0d", c), res_z,
                  alm_model(fa[bps[c].exp_id], fb[bps[c].exp_id]));
         end
         tick();
      end
      @(negedge clk);
      check("bp count", op_count, 32'd3);
      check("bp idle", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
